// File: rtl/ntt_param_pkg.sv
// Shared constants, zeta table, FSM state and coefficient types for the NTT core.
// Twiddles are plain (non-Montgomery) powers of 1753, a 512th root of unity mod Q.
package ntt_param_pkg;

   localparam int CW = 23;
   localparam int NTT_Q = 8380417;
   localparam int NTT_ROOT = 1753;

   typedef logic [CW-1:0] coeff_t;
   typedef logic [255:0][CW-1:0] zeta_tab_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_UNLOAD
   } state_t;

   // N divides Q-1, so N * ((Q-1)/N) = -1 and N^-1 = Q - (Q-1)/N.
   function automatic int ninv_of(input int n, input int q);
      return q - (q - 1) / n;
   endfunction

   localparam int NTT_NINV = ninv_of(256, NTT_Q);

   function automatic logic [7:0] brv8(input logic [7:0] v);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = v[7-b];
      return r;
   endfunction

   function automatic zeta_tab_t gen_zetas();
      zeta_tab_t pw;
      zeta_tab_t t;
      logic [63:0] p;
      pw = '0;
      pw[0] = coeff_t'(1);
      for (int i = 1; i < 256; i++) begin
         p = 64'(pw[8'(i - 1)]) * 64'(NTT_ROOT);
         pw[8'(i)] = coeff_t'(p % 64'(NTT_Q));
      end
      for (int k = 0; k < 256; k++) t[8'(k)] = pw[brv8(8'(k))];
      return t;
   endfunction

   localparam zeta_tab_t ZETAS = gen_zetas();

   function automatic coeff_t mod_add(input coeff_t a, input coeff_t b,
                                      input coeff_t q);
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[CW-1:0];
   endfunction

   function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b,
                                      input coeff_t q);
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, q} - {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[CW-1:0];
   endfunction

   function automatic coeff_t mod_mul(input coeff_t a, input coeff_t b,
                                      input coeff_t q);
      logic [2*CW-1:0] p;
      p = {{CW{1'b0}}, a} * {{CW{1'b0}}, b};
      p = p % {{CW{1'b0}}, q};
      return p[CW-1:0];
   endfunction

endpackage

// File: rtl/parallel_ntt_butterfly.sv
// Combinational NTT butterfly: Cooley-Tukey when inv=0, Gentleman-Sande when inv=1.
// A single modular multiplier is shared by both flavours.
module ntt_butterfly
   import ntt_param_pkg::*;
#(
   parameter int Q = NTT_Q
) (
   input  logic          inv,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic [CW-1:0] zeta,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y
);

   localparam coeff_t QC = coeff_t'(Q);

   logic [CW-1:0] d;
   logic [CW-1:0] m;

   always_comb begin
      d = mod_sub(a, b, QC);
      m = mod_mul(inv ? d : b, zeta, QC);
      if (inv) begin
         x = mod_add(a, b, QC);
         y = m;
      end else begin
         x = mod_add(a, m, QC);
         y = mod_sub(a, m, QC);
      end
   end

endmodule

// File: rtl/parallel_ntt_param.sv
// In-place iterative NTT, one butterfly per clock, with load/unload streams.
// Define NTT_INVERSE_EN to build the inverse transform and N^-1 unload scaler.
module parallel_ntt_param
   import ntt_param_pkg::*;
#(
   parameter int N       = 256,
   parameter int COEFF_W = 32,
   parameter int Q       = NTT_Q
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               in_valid,
   input  logic [COEFF_W-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [COEFF_W-1:0] out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic               done
);

   localparam int LOGN = $clog2(N);
   localparam int HW = LOGN - 1;
   localparam coeff_t QC = coeff_t'(Q);
   localparam logic [COEFF_W-1:0] QW = COEFF_W'(Q);
   localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
   localparam logic [HW-1:0] BLAST = HW'(N / 2 - 1);
   localparam logic [3:0] LLAST = 4'(LOGN - 1);
   localparam logic [LOGN:0] NW = (LOGN + 1)'(N);

   state_t          state;
   logic [LOGN-1:0] cnt;
   logic [HW-1:0]   bc;
   logic [3:0]      layer;
   logic            inv;

   coeff_t mem [N];

   logic [3:0]      s;
   logic [HW-1:0]   g;
   logic [HW-1:0]   o;
   logic [LOGN-1:0] lo;
   logic [LOGN-1:0] hi;
   logic [LOGN-1:0] zk;
   coeff_t          za;
   coeff_t          zeta;
   coeff_t          bx;
   coeff_t          by;
   coeff_t          ld;
   coeff_t          rd;
   coeff_t          res;

`ifdef NTT_INVERSE_EN
   localparam coeff_t NINV = coeff_t'((N == 256) ? NTT_NINV : ninv_of(N, Q));
   logic mode_q;
   assign inv = mode_q;
   assign res = inv ? mod_mul(rd, NINV, QC) : rd;
`else
   logic mode_unused;
   assign mode_unused = mode;
   assign inv = 1'b0;
   assign res = rd;
`endif

   // Butterfly addressing: s is log2 of the half-span of the current layer.
   always_comb begin
      s = inv ? layer : LLAST - layer;
      g = bc >> s;
      o = bc & ((HW'(1) << s) - HW'(1));
      lo = ({1'b0, g} << (s + 4'd1)) | {1'b0, o};
      hi = lo | (LOGN'(1) << s);
      if (inv) zk = LOGN'((NW >> s) - (LOGN + 1)'(1) - {2'b00, g});
      else zk = LOGN'((NW >> (s + 4'd1)) + {2'b00, g});
      za = ZETAS[8'(zk)];
      zeta = inv ? QC - za : za;
   end

   ntt_butterfly #(
      .Q(Q)
   ) u_bfly (
      .inv (inv),
      .a   (mem[lo]),
      .b   (mem[hi]),
      .zeta(zeta),
      .x   (bx),
      .y   (by)
   );

   assign ld = (in_data >= QW) ? coeff_t'(in_data - QW) : coeff_t'(in_data);
   assign rd = mem[cnt];
   assign out_data = {{(COEFF_W - CW){1'b0}}, res};

   always_ff @(posedge clock) begin
      if (state == S_LOAD && in_valid) begin
         mem[cnt] <= ld;
      end else if (state == S_COMPUTE) begin
         mem[lo] <= bx;
         mem[hi] <= by;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         bc        <= '0;
         layer     <= '0;
`ifdef NTT_INVERSE_EN
         mode_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LOAD;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
                  cnt      <= '0;
`ifdef NTT_INVERSE_EN
                  mode_q   <= mode;
`endif
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state    <= S_COMPUTE;
                     in_ready <= 1'b0;
                     cnt      <= '0;
                     bc       <= '0;
                     layer    <= '0;
                  end
               end
            end
            S_COMPUTE: begin
               bc <= bc + 1'b1;
               if (bc == BLAST) begin
                  layer <= layer + 4'd1;
                  if (layer == LLAST) begin
                     state     <= S_UNLOAD;
                     out_valid <= 1'b1;
                     layer     <= '0;
                     cnt       <= '0;
                  end
               end
            end
            S_UNLOAD: begin
               if (out_ready) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state     <= S_IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cnt       <= '0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
